// File: rtl/bpu_btb_pkg.sv
// Shared definitions for the branch predictor: PC field positions and the
// index-width helper used to size the BTB.
package bpu_btb_pkg;

    // PCs are word aligned, so bits [1:0] never take part in indexing.
    localparam int IDX_LSB       = 2;
    localparam int CNT_W_DEFAULT = 2;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << r) < value) r++;
        end
        return r;
    endfunction

    function automatic int tag_lsb(input int idx_w);
        return idx_w + IDX_LSB;
    endfunction

endpackage

// File: rtl/bpu_sat_ctr.sv
// Saturating up/down next-value function; holds when inc and dec are both
// asserted or when the requested step would wrap.
module bpu_sat_ctr #(
    parameter int W = 2
) (
    input  logic [W-1:0] value,
    input  logic         inc,
    input  logic         dec,
    output logic [W-1:0] next
);

    always_comb begin
        next = value;
        if (inc && !dec && (value != '1)) begin
            next = value + W'(1);
        end else if (dec && !inc && (value != '0)) begin
            next = value - W'(1);
        end
    end

endmodule

// File: rtl/bpu_btb.sv
// Direct-mapped BTB with per-entry saturating direction counters, a
// combinational mispredict flag and saturating performance counters.
module bpu_btb
    import bpu_btb_pkg::*;
#(
    parameter int ENTRIES  = 64,
    parameter int ADDR_W   = 32,
    parameter int TAG_W    = 8,
    parameter int CNT_W    = CNT_W_DEFAULT,
    parameter int INIT_CNT = 1,
    parameter int PERF_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              pred_hit,
    output logic              pred_taken,
    output logic [ADDR_W-1:0] pred_target,
    input  logic              upd_valid,
    input  logic [ADDR_W-1:0] upd_pc,
    input  logic              upd_taken,
    input  logic [ADDR_W-1:0] upd_target,
    input  logic              upd_is_jump,
    input  logic              upd_pred_taken,
    input  logic [ADDR_W-1:0] upd_pred_target,
    output logic              upd_mispred,
    output logic [PERF_W-1:0] perf_updates,
    output logic [PERF_W-1:0] perf_mispred
);

    localparam int IDX_W   = clog2(ENTRIES);
    localparam int TAG_LSB = tag_lsb(IDX_W);
    localparam int TAG_MSB = TAG_LSB + TAG_W - 1;
    localparam logic [CNT_W-1:0] INIT_VAL   = CNT_W'(INIT_CNT);
    localparam logic [CNT_W-1:0] WEAK_TAKEN = CNT_W'(1 << (CNT_W - 1));

    logic              valid_reg  [ENTRIES];
    logic              jmp_reg    [ENTRIES];
    logic [TAG_W-1:0]  tag_reg    [ENTRIES];
    logic [ADDR_W-1:0] target_reg [ENTRIES];
    logic [CNT_W-1:0]  cnt_reg    [ENTRIES];

    logic [PERF_W-1:0] perf_updates_reg;
    logic [PERF_W-1:0] perf_mispred_reg;
    logic [PERF_W-1:0] perf_updates_next;
    logic [PERF_W-1:0] perf_mispred_next;

    logic [IDX_W-1:0] lookup_idx;
    logic [TAG_W-1:0] lookup_tag;
    logic [IDX_W-1:0] upd_idx;
    logic [TAG_W-1:0] upd_tag;
    logic             upd_hit;
    logic [CNT_W-1:0] cnt_next;

    assign lookup_idx = lookup_pc[TAG_LSB-1:IDX_LSB];
    assign lookup_tag = lookup_pc[TAG_MSB:TAG_LSB];
    assign upd_idx    = upd_pc[TAG_LSB-1:IDX_LSB];
    assign upd_tag    = upd_pc[TAG_MSB:TAG_LSB];

    // Lookup sees the pre-update state of the array; there is no bypass.
    assign pred_hit    = valid_reg[lookup_idx] && (tag_reg[lookup_idx] == lookup_tag);
    assign pred_taken  = pred_hit && (jmp_reg[lookup_idx] || cnt_reg[lookup_idx][CNT_W-1]);
    assign pred_target = pred_taken ? target_reg[lookup_idx] : lookup_pc + ADDR_W'(4);

    assign upd_mispred = upd_valid &&
                         ((upd_taken != upd_pred_taken) ||
                          (upd_taken && (upd_target != upd_pred_target)));

    assign upd_hit = valid_reg[upd_idx] && (tag_reg[upd_idx] == upd_tag);

    bpu_sat_ctr #(.W(CNT_W)) u_dir_ctr (
        .value (cnt_reg[upd_idx]),
        .inc   (upd_taken),
        .dec   (!upd_taken),
        .next  (cnt_next)
    );

    bpu_sat_ctr #(.W(PERF_W)) u_perf_updates (
        .value (perf_updates_reg),
        .inc   (upd_valid),
        .dec   (1'b0),
        .next  (perf_updates_next)
    );

    bpu_sat_ctr #(.W(PERF_W)) u_perf_mispred (
        .value (perf_mispred_reg),
        .inc   (upd_mispred),
        .dec   (1'b0),
        .next  (perf_mispred_next)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < ENTRIES; i++) begin
                valid_reg[i]  <= 1'b0;
                jmp_reg[i]    <= 1'b0;
                tag_reg[i]    <= '0;
                target_reg[i] <= '0;
                cnt_reg[i]    <= INIT_VAL;
            end
            perf_updates_reg <= '0;
            perf_mispred_reg <= '0;
        end else begin
            perf_updates_reg <= perf_updates_next;
            perf_mispred_reg <= perf_mispred_next;
            if (upd_valid) begin
                if (upd_hit) begin
                    cnt_reg[upd_idx] <= cnt_next;
                    jmp_reg[upd_idx] <= upd_is_jump;
                    if (upd_taken) target_reg[upd_idx] <= upd_target;
                end else if (upd_taken) begin
                    // Allocation evicts whatever alias currently owns the slot.
                    valid_reg[upd_idx]  <= 1'b1;
                    tag_reg[upd_idx]    <= upd_tag;
                    target_reg[upd_idx] <= upd_target;
                    jmp_reg[upd_idx]    <= upd_is_jump;
                    cnt_reg[upd_idx]    <= WEAK_TAKEN;
                end
            end
        end
    end

    assign perf_updates = perf_updates_reg;
    assign perf_mispred = perf_mispred_reg;

    logic unused_pc_bits;
    generate
        if (ADDR_W > TAG_MSB + 1) begin : g_upper
            assign unused_pc_bits = ^{lookup_pc[IDX_LSB-1:0], upd_pc[IDX_LSB-1:0],
                                      lookup_pc[ADDR_W-1:TAG_MSB+1], upd_pc[ADDR_W-1:TAG_MSB+1]};
        end else begin : g_no_upper
            assign unused_pc_bits = ^{lookup_pc[IDX_LSB-1:0], upd_pc[IDX_LSB-1:0]};
        end
    endgenerate

endmodule

// File: tb/tb_bpu_btb.sv
// Directed scoreboard bench for bpu_btb: stimulus queues expectations per
// cycle, a separate monitor compares them against the DUT mid-cycle.
module tb_bpu_btb;

    localparam int ADDR_W = 32;
    localparam int PERF_W = 4;

    localparam int K_HIT = 0, K_TAKEN = 1, K_TARGET = 2, K_MISP = 3, K_PUPD = 4, K_PMIS = 5;

    typedef struct {
        int          cyc;
        string       name;
        int          kind;
        logic [31:0] exp;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic [ADDR_W-1:0] lookup_pc = '0;
    logic              pred_hit;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_target;
    logic              upd_valid = 1'b0;
    logic [ADDR_W-1:0] upd_pc = '0;
    logic              upd_taken = 1'b0;
    logic [ADDR_W-1:0] upd_target = '0;
    logic              upd_is_jump = 1'b0;
    logic              upd_pred_taken = 1'b0;
    logic [ADDR_W-1:0] upd_pred_target = '0;
    logic              upd_mispred;
    logic [PERF_W-1:0] perf_updates;
    logic [PERF_W-1:0] perf_mispred;

    exp_t exp_q[$];
    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   done = 1'b0;

    bpu_btb #(
        .ENTRIES(64), .ADDR_W(ADDR_W), .TAG_W(8), .CNT_W(2), .INIT_CNT(1), .PERF_W(PERF_W)
    ) dut (
        .clk(clk), .rst(rst), .lookup_pc(lookup_pc),
        .pred_hit(pred_hit), .pred_taken(pred_taken), .pred_target(pred_target),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_taken(upd_taken),
        .upd_target(upd_target), .upd_is_jump(upd_is_jump),
        .upd_pred_taken(upd_pred_taken), .upd_pred_target(upd_pred_target),
        .upd_mispred(upd_mispred), .perf_updates(perf_updates), .perf_mispred(perf_mispred)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic drive(input logic [31:0] lpc, input logic uv, input logic [31:0] upc,
                         input logic ut, input logic [31:0] utgt, input logic uj,
                         input logic upt, input logic [31:0] uptgt);
        lookup_pc       = lpc;
        upd_valid       = uv;
        upd_pc          = upc;
        upd_taken       = ut;
        upd_target      = utgt;
        upd_is_jump     = uj;
        upd_pred_taken  = upt;
        upd_pred_target = uptgt;
    endtask

    task automatic idle(input logic [31:0] lpc);
        drive(lpc, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
    endtask

    task automatic expect_val(input string name, input int kind, input logic [31:0] value);
        exp_t e;
        e.cyc  = cyc;
        e.name = name;
        e.kind = kind;
        e.exp  = value;
        exp_q.push_back(e);
    endtask

    task automatic expect_lookup(input string name, input logic h, input logic t, input logic [31:0] tgt);
        expect_val({name, "_hit"}, K_HIT, {31'd0, h});
        expect_val({name, "_taken"}, K_TAKEN, {31'd0, t});
        expect_val({name, "_target"}, K_TARGET, tgt);
    endtask

    // Monitor: compare every expectation queued for the current cycle.
    always @(negedge clk) begin
        logic [31:0] act;
        exp_t        e;
        #2;
        while (exp_q.size() > 0 && exp_q[0].cyc <= cyc) begin
            e = exp_q.pop_front();
            case (e.kind)
                K_HIT:    act = {31'd0, pred_hit};
                K_TAKEN:  act = {31'd0, pred_taken};
                K_TARGET: act = pred_target;
                K_MISP:   act = {31'd0, upd_mispred};
                K_PUPD:   act = {28'd0, perf_updates};
                default:  act = {28'd0, perf_mispred};
            endcase
            n_tests++;
            if (e.cyc != cyc || act !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", e.name, act, e.exp, cyc);
            end else begin
                $display("[TB] ok %s = 0x%0h", e.name, act);
            end
        end
    end

    initial begin
        // Power-on reset.
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        idle(32'h100);
        expect_lookup("por", 1'b0, 1'b0, 32'h104);
        expect_val("por_pupd", K_PUPD, 32'd0);
        expect_val("por_pmis", K_PMIS, 32'd0);

        // Taken branch allocates with a weakly-taken counter.
        @(negedge clk);
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        expect_val("alloc_misp", K_MISP, 32'd1);
        expect_val("alloc_same_cycle_hit", K_HIT, 32'd0);
        @(negedge clk);
        idle(32'h40);
        expect_lookup("alloc_next", 1'b1, 1'b1, 32'h20);
        expect_val("alloc_pmis", K_PMIS, 32'd1);
        expect_val("alloc_pupd", K_PUPD, 32'd1);

        // Train up to saturation, then down twice.
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b1, 32'h20);
            expect_val("train_up_misp", K_MISP, 32'd0);
        end
        @(negedge clk);
        drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
        expect_val("dn1_misp", K_MISP, 32'd1);
        expect_lookup("dn1_pre", 1'b1, 1'b1, 32'h20);
        @(negedge clk);
        idle(32'h40);
        expect_lookup("cnt2", 1'b1, 1'b1, 32'h20);
        expect_val("cnt2_pupd", K_PUPD, 32'd4);
        expect_val("cnt2_pmis", K_PMIS, 32'd2);
        @(negedge clk);
        drive(32'h40, 1'b1, 32'h40, 1'b0, 32'h0, 1'b0, 1'b1, 32'h20);
        expect_val("dn2_misp", K_MISP, 32'd1);
        @(negedge clk);
        idle(32'h40);
        expect_lookup("cnt1", 1'b1, 1'b0, 32'h44);
        expect_val("cnt1_pmis", K_PMIS, 32'd3);

        // Alias at 0x140 shares idx 0x10 with tag 0x01.
        @(negedge clk);
        drive(32'h140, 1'b1, 32'h140, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        expect_lookup("alias_miss", 1'b0, 1'b0, 32'h144);
        expect_val("alias_nt_misp", K_MISP, 32'd0);
        @(negedge clk);
        drive(32'h40, 1'b1, 32'h140, 1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        expect_val("alias_keep_hit", K_HIT, 32'd1);
        expect_val("alias_t_misp", K_MISP, 32'd1);
        @(negedge clk);
        idle(32'h140);
        expect_lookup("alias_new", 1'b1, 1'b1, 32'h300);
        @(negedge clk);
        idle(32'h40);
        expect_lookup("alias_evicted", 1'b0, 1'b0, 32'h44);

        // Jump entry predicts taken regardless of the counter.
        @(negedge clk);
        drive(32'h80, 1'b1, 32'h80, 1'b1, 32'h200, 1'b1, 1'b0, 32'h0);
        expect_val("jal_misp", K_MISP, 32'd1);
        @(negedge clk);
        drive(32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        expect_lookup("jal_pred", 1'b1, 1'b1, 32'h200);
        expect_val("jal_nt_misp", K_MISP, 32'd1);
        @(negedge clk);
        drive(32'h80, 1'b1, 32'h80, 1'b0, 32'h0, 1'b1, 1'b1, 32'h200);
        expect_lookup("jal_cnt1", 1'b1, 1'b1, 32'h200);
        @(negedge clk);
        idle(32'h80);
        expect_lookup("jal_cnt0", 1'b1, 1'b1, 32'h200);
        expect_val("jal_pupd", K_PUPD, 32'd10);
        expect_val("jal_pmis", K_PMIS, 32'd7);

        // Asynchronous reset between edges, with an update pending.
        @(negedge clk);
        rst = 1'b0;
        drive(32'h100, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b1, 32'h20);
        expect_lookup("arst", 1'b0, 1'b0, 32'h104);
        expect_val("arst_pupd", K_PUPD, 32'd0);
        expect_val("arst_pmis", K_PMIS, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        idle(32'h40);
        expect_lookup("arst_discard", 1'b0, 1'b0, 32'h44);
        expect_val("arst_discard_pupd", K_PUPD, 32'd0);
        @(negedge clk);
        idle(32'h80);
        expect_lookup("arst_jal_gone", 1'b0, 1'b0, 32'h84);

        // Same-cycle lookup and update: no bypass.
        @(negedge clk);
        drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
        expect_val("byp_same_hit", K_HIT, 32'd0);
        expect_val("byp_misp", K_MISP, 32'd1);
        @(negedge clk);
        idle(32'h40);
        expect_lookup("byp_next", 1'b1, 1'b1, 32'h20);
        expect_val("byp_pupd", K_PUPD, 32'd1);
        expect_val("byp_pmis", K_PMIS, 32'd1);

        // 2^PERF_W+2 mispredicting updates: both counters stop at 0xF.
        for (int k = 0; k < 18; k++) begin
            @(negedge clk);
            drive(32'h40, 1'b1, 32'h40, 1'b1, 32'h20, 1'b0, 1'b0, 32'h0);
            expect_val("sat_pmis", K_PMIS, (k + 1 > 15) ? 32'd15 : 32'(k + 1));
            expect_val("sat_pupd", K_PUPD, (k + 1 > 15) ? 32'd15 : 32'(k + 1));
        end
        @(negedge clk);
        idle(32'h40);
        expect_val("sat_final_pmis", K_PMIS, 32'd15);
        expect_val("sat_final_pupd", K_PUPD, 32'd15);

        repeat (2) @(negedge clk);
        #4;
        if (exp_q.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
        end
        done = 1'b1;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        if (!done) begin
            $display("FAIL watchdog: got timeout expected completion");
            $fatal(1, "watchdog");
        end
    end

endmodule

// File: doc/bpu_btb.md
Name: bpu_btb

Overview:
Parametrised branch predictor for the RV32I pipeline: a direct-mapped branch target buffer combined with per-entry N-bit saturating direction counters.
- Fetch stage: queries it combinationally with the current PC to choose the next PC.
- Execute stage: trains it with the resolved outcome. The block reports a mispredict flag that drives the pipeline flush.
- Replaces the current static "predict not-taken" next-PC path and adds counter width, depth and jump modes.
- Includes saturating performance counters.

Parameters:
ENTRIES, 64, number of BTB entries; must be a power of 2, >=2; IDX_W = log2(ENTRIES)
ADDR_W, 32, PC/target width
TAG_W, 8, stored tag bits; requires IDX_W+2+TAG_W <= ADDR_W
CNT_W, 2, direction counter width; >=1
INIT_CNT, 1, counter reset value; must be < 2^CNT_W
PERF_W, 32, performance counter width

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous active-low reset (0 = reset)
lookup_pc  in  ADDR_W  fetch-stage PC
pred_hit  out  1  valid entry with matching tag
pred_taken  out  1  predicted taken
pred_target  out  ADDR_W  predicted next PC
upd_valid  in  1  resolved control-transfer instruction this cycle
upd_pc  in  ADDR_W  PC of the resolved instruction
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual target, from the JB unit
upd_is_jump  in  1  JAL/JALR (unconditional)
upd_pred_taken  in  1  prediction made at fetch, carried down the pipe
upd_pred_target  in  ADDR_W  predicted target, carried down the pipe
upd_mispred  out  1  combinational mispredict flag
perf_updates  out  PERF_W  count of upd_valid cycles
perf_mispred  out  PERF_W  count of mispredicts

Behaviour:
Address fields:
- idx = pc[IDX_W+1:2]
- tag = pc[IDX_W+1+TAG_W : IDX_W+2]
- Each entry holds: valid, tag, target, cnt[CNT_W], jmp.

Lookup (combinational, zero latency):
- pred_hit = valid[idx] & (tag match).
- pred_taken = pred_hit & (jmp | cnt MSB).
- pred_target = entry target when pred_taken, else lookup_pc+4, wrapping modulo 2^ADDR_W.

Mispredict (combinational):
- upd_mispred = upd_valid & ((upd_taken != upd_pred_taken) | (upd_taken & upd_target != upd_pred_target)).

Update (registered on the rising clk edge when upd_valid):
- Entry hit:
  - taken: cnt saturating +1, and target <= upd_target.
  - not-taken: cnt saturating -1, floor 0.
  - jmp <= upd_is_jump.
- Entry miss, taken: allocate and overwrite any alias. valid=1, tag, target, jmp=upd_is_jump, cnt = 2^(CNT_W-1) (weakly taken).
- Entry miss, not-taken: no change.
- A jmp entry always predicts taken, whatever cnt holds.

Simultaneous events:
- Lookup and update to the same idx in the same cycle: lookup returns the pre-update state. There is no bypass.
- The new state is visible the cycle after the update edge.

Performance counters:
- perf_updates +1 per upd_valid cycle.
- perf_mispred +1 per upd_mispred cycle.
- Both saturate at all-ones and do not wrap.

Reset (rst=0, asynchronous, any time including mid-update):
- All valid=0, cnt=INIT_CNT, jmp=0, tags/targets=0, perf counters=0.
- Resulting outputs: pred_hit=0, pred_taken=0, pred_target=lookup_pc+4.
- An update edge coincident with reset is discarded.
- Deassertion has no special handling; the first update takes effect on the first clk edge with rst=1.

Decomposition:
- Shared constants header (bpu_defs): entry field offsets, CNT_W default, and the idx/tag extraction expressed via IDX_W. An IDX_W clog2 helper function lives there.
- One sub-module: bpu_sat_ctr, a parametrised CNT_W saturating up/down next-value function. It is reused for each entry update and, with width PERF_W, for the perf counters.
- Entry storage is a flop array, not SRAM, so lookup can be combinational.

Test Plan:
1. Async reset mid-run (rst=0 between clock edges) -> outputs clear immediately: lookup_pc=0x100 gives pred_hit=0, pred_taken=0, pred_target=0x104; perf_updates=0.
2. Update pc=0x40, taken, target=0x20, pred_taken=0 -> upd_mispred=1 that cycle; next cycle lookup 0x40 gives hit=1, taken=1, target=0x20; cnt=2; perf_mispred=1.
3. Two more taken updates at 0x40 -> cnt saturates at 3. Then not-taken -> cnt 2, still predicts taken. Not-taken again -> cnt 1, lookup gives taken=0, target=0x44.
4. Alias: entry at 0x40 valid, lookup 0x140 (same idx 0x10, tag 0x01 vs 0x00) -> hit=0. Not-taken update at 0x140 -> no change. Taken update at 0x140 -> replaces entry, and 0x40 now misses.
5. JAL at pc=0x80, target 0x200, is_jump -> predicts taken. A later upd_taken=0 with is_jump=1 decrements cnt, yet pred_taken stays 1.
6. Same-cycle lookup and update of 0x40 (fresh reset) -> lookup returns hit=0 that cycle and hit=1 the next. Driving 2^PERF_W+2 mispredicting updates with PERF_W=4 -> perf_mispred holds at 0xF.
